cordic_fixedpoint_result_reader: RTL
====================================

# cordic_fixedpoint_result_reader

Read side of the CORDIC result FIFO. The pipeline control logic writes finished rotations into the FIFO; this block drains it and presents each result downstream on a valid/ready handshake. A 2-entry output buffer hides the FIFO's 1-cycle read latency, so the block sustains one result per cycle under no backpressure. It also marks frame boundaries and counts delivered results.

## Interface
- RESULT_WIDTH, 32: width of one FIFO word, which packs {cos, sin}.
- COUNT_WIDTH, 16: width of the frame-length input and the result counter.

- iClk  in  1  clock; reset iReset_n, synchronous, active-low
- iReset_n  in  1  synchronous active-low reset
- iFifo_empty  in  1  result FIFO empty flag
- iFifo_q  in  RESULT_WIDTH  FIFO read data, valid the cycle after a read request
- oFifo_read_request  out  1  FIFO pop request, combinational
- oResult_valid  out  1  head buffer entry valid
- oResult_data  out  RESULT_WIDTH  head entry data
- iResult_ready  in  1  downstream accepts
- oResult_last  out  1  head entry is the last result of its frame
- iFrame_length  in  COUNT_WIDTH  results per frame; 0 disables framing
- oResult_count  out  COUNT_WIDTH  total results accepted downstream, wraps
- oBusy  out  1  buffer non-empty or a read is in flight

## Operation
- State:
  - occ: buffer occupancy, 0..2.
  - inflight: 1 bit, set the cycle after a read request.
  - 2-entry FIFO-ordered buffer with a head pointer.
  - frame counter fcnt.
  - oResult_count.
- pop = oResult_valid & iResult_ready.
- oFifo_read_request = ~iFifo_empty & (occ + inflight - pop < 2).
  - Never asserted while iFifo_empty.
  - The buffer never overflows.
- inflight <= oFifo_read_request.
  - When inflight = 1, iFifo_q is written into the tail entry at the end of that cycle.
- occ update: occ_next = occ + inflight - pop.
  - Simultaneous write and pop of the same entry is legal when occ = 1.
  - When occ = 0, a write and a pop in the same cycle cannot happen, because valid is registered.
- oResult_valid = (occ != 0).
- oResult_data is the head entry. It must stay stable while valid & ~ready.
- oResult_last:
  - = oResult_valid & (iFrame_length != 0) & (fcnt == iFrame_length - 1).
- On pop:
  - oResult_count increments, modulo 2^COUNT_WIDTH.
  - fcnt increments. It wraps to 0 on a pop with oResult_last high.
  - When iFrame_length = 0, fcnt stays 0.
- iFrame_length must be held constant while oBusy = 1 or fcnt != 0. Changing it otherwise is undefined.
- oBusy = (occ != 0) | inflight.

## Timing
- Reset values: occ = 0, inflight = 0, fcnt = 0, oResult_count = 0.
  - Outputs: oResult_valid = 0, oResult_last = 0, oBusy = 0, oResult_data = 0.
  - oFifo_read_request still follows iFifo_empty during reset; the FIFO owner also resets.
- Reset asserted mid-operation:
  - Buffer contents and inflight are discarded.
  - The data word returning in the cycle after reset is dropped, not written.
- Latency: FIFO non-empty with an empty buffer at cycle t gives:
  - read request in cycle t;
  - data captured at the end of t+1;
  - oResult_valid = 1 in cycle t+2.
- Throughput: 1 result per cycle in steady state (occ = 1, inflight = 1, ready = 1).
- Backpressure: with ready = 0, reads stop once occ + inflight = 2. No FIFO word is read that cannot be stored.
- FIFO empty while entries are buffered: buffered entries still drain; valid drops when occ reaches 0.

## Test plan
- Single word: FIFO holds 0xA5A51234, ready = 1 → read request in cycle 0; valid with data 0xA5A51234 in cycle 2 for exactly 1 cycle; count = 1; oBusy = 0 by cycle 3.
- Streaming: 16 words 0..15 preloaded, ready held at 1 → valid on 16 consecutive cycles, data 0..15 in order; exactly 16 read requests.
- Backpressure: 8 words, ready toggled 1,0,0,1… by a random pattern →
  - no loss and no duplication;
  - data stable while stalled;
  - occ never exceeds 2;
  - no read request while occ + inflight - pop = 2.
- Framing: iFrame_length = 3, 7 words → oResult_last on results 3 and 6 only; fcnt = 1 at the end. Repeat with iFrame_length = 0 → oResult_last never asserted.
- Empty FIFO: iFifo_empty held at 1 for 20 cycles → no read request, valid = 0, oBusy = 0.
- Reset mid-stream: reset asserted while occ = 2 and inflight = 1 → next cycle valid = 0 and count = 0; the returning word is dropped; streaming restarts cleanly after release.

Source files
------------

// File: rtl/cordic_fixedpoint_result_reader_if.sv
// Handshake bundle between the CORDIC result FIFO, the result reader and the
// downstream consumer: FIFO read port, result stream and framing/status.
interface cordic_fixedpoint_result_reader_if #(
  parameter int RESULT_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
);
  logic                    fifo_empty;
  logic [RESULT_WIDTH-1:0] fifo_q;
  logic                    fifo_read_request;
  logic                    result_valid;
  logic [RESULT_WIDTH-1:0] result_data;
  logic                    result_ready;
  logic                    result_last;
  logic [COUNT_WIDTH-1:0]  frame_length;
  logic [COUNT_WIDTH-1:0]  result_count;
  logic                    busy;

  // Reader side: pops the FIFO and sources the result stream.
  modport master (
    input  fifo_empty, fifo_q, result_ready, frame_length,
    output fifo_read_request, result_valid, result_data, result_last,
           result_count, busy
  );

  // Environment side: owns the FIFO and consumes results.
  modport slave (
    output fifo_empty, fifo_q, result_ready, frame_length,
    input  fifo_read_request, result_valid, result_data, result_last,
           result_count, busy
  );
endinterface

// File: rtl/cordic_fixedpoint_result_reader.sv
// Drains the CORDIC result FIFO into a 2-entry skid buffer that hides the
// FIFO's 1-cycle read latency, and streams results out with frame marking.
module cordic_fixedpoint_result_reader #(
  parameter int RESULT_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic iClk,
  input  logic iReset_n,
  cordic_fixedpoint_result_reader_if.master bus
);

  logic [1:0]              occ;
  logic                    inflight;
  logic                    head;
  logic                    tail;
  logic [RESULT_WIDTH-1:0] ent [2];
  logic [COUNT_WIDTH-1:0]  fcnt;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    valid;
  logic                    pop;
  logic                    last;
  logic                    framing;
  logic [2:0]              level;

  assign valid   = (occ != 2'd0);
  assign pop     = valid & bus.result_ready;
  assign framing = (bus.frame_length != '0);
  assign last    = valid & framing & (fcnt == bus.frame_length - COUNT_WIDTH'(1));

  // Entries held after this cycle, counting the word still returning from the FIFO.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // The returning word lands behind the head; with occ = 1 and a pop this is
  // the entry the head is about to move onto.
  assign tail = head ^ occ[0];

  assign bus.fifo_read_request = ~bus.fifo_empty & (level < 3'd2);
  assign bus.result_valid      = valid;
  assign bus.result_data       = valid ? ent[head] : '0;
  assign bus.result_last       = last;
  assign bus.result_count      = count;
  assign bus.busy              = valid | inflight;

  // Control stage: occupancy, read tracking, head pointer and counters.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      fcnt     <= '0;
      count    <= '0;
    end else begin
      inflight <= bus.fifo_read_request;
      occ      <= level[1:0];
      if (pop) begin
        head  <= ~head;
        count <= count + COUNT_WIDTH'(1);
        if (!framing || last) begin
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Data stage: a word returning across reset is dropped with its tracking state.
  always_ff @(posedge iClk) begin
    if (iReset_n && inflight) begin
      ent[tail] <= bus.fifo_q;
    end
  end

endmodule
